cnn_stage_sequencer: RTL and testbench

- Parametrised controller that runs a chain of NUM_STAGES compute layers (conv, pool, fc, ...) in order. Each stage gets a one-cycle start pulse, and the controller waits for that stage's done before moving on.
- Adds features the fixed 3-layer controller lacked: per-run stage bypass, per-stage timeout with error reporting, optional output ReLU, and a run cycle counter.
- Sits at the top of the CNN core, between the host enable/done handshake and the layer engines.

---
 rtl/cnn_stage_sequencer_if.sv | 32 +++
 rtl/cnn_stage_sequencer.sv | 148 ++++++++++++++
 tb/tb_cnn_stage_sequencer.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cnn_stage_sequencer_if.sv
// Host/stage-engine bundle for the CNN stage sequencer.
// The master side drives run requests and stage responses; the slave side is the sequencer.
interface cnn_stage_sequencer_if #(
    parameter int NUM_STAGES = 3,
    parameter int DATA_W     = 32,
    parameter int CNT_W      = 32
);
    localparam int ERR_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    logic                  enable;
    logic [NUM_STAGES-1:0] bypass_mask;
    logic                  relu_en;
    logic [NUM_STAGES-1:0] stage_start;
    logic [NUM_STAGES-1:0] stage_done;
    logic [DATA_W-1:0]     final_in;
    logic [DATA_W-1:0]     value;
    logic                  done;
    logic                  busy;
    logic                  timeout_err;
    logic [ERR_W-1:0]      err_stage;
    logic [CNT_W-1:0]      cycle_count;

    modport master (
        output enable, bypass_mask, relu_en, stage_done, final_in,
        input  stage_start, value, done, busy, timeout_err, err_stage, cycle_count
    );

    modport slave (
        input  enable, bypass_mask, relu_en, stage_done, final_in,
        output stage_start, value, done, busy, timeout_err, err_stage, cycle_count
    );
endinterface

// File: rtl/cnn_stage_sequencer.sv
// Runs NUM_STAGES layer engines in order with per-run bypass, per-stage timeout,
// optional output ReLU and a LAUNCH+WAIT cycle counter.
module cnn_stage_sequencer #(
    parameter int NUM_STAGES = 3,
    parameter int DATA_W     = 32,
    parameter int TIMEOUT    = 1023,
    parameter int CNT_W      = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    cnn_stage_sequencer_if.slave bus
);
    localparam int IDX_W  = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_FINISH, S_ERROR} state_t;

    state_t                state_reg;
    logic [IDX_W-1:0]      idx_reg;
    logic [WAIT_W-1:0]     wait_cnt_reg;
    logic [NUM_STAGES-1:0] mask_reg;
    logic [NUM_STAGES-1:0] stage_start_reg;
    logic [DATA_W-1:0]     value_reg;
    logic                  done_reg;
    logic                  busy_reg;
    logic                  timeout_err_reg;
    logic [IDX_W-1:0]      err_stage_reg;
    logic [CNT_W-1:0]      cycle_count_reg;

    logic [NUM_STAGES-1:0] first_cand;
    logic [NUM_STAGES-1:0] next_cand;
    logic [IDX_W-1:0]      first_idx;
    logic [IDX_W-1:0]      next_idx;
    logic                  first_any;
    logic                  next_any;
    logic [DATA_W-1:0]     result;
    logic [CNT_W-1:0]      cycle_count_next;
    logic                  timed_out;

    function automatic logic [IDX_W-1:0] lowest(input logic [NUM_STAGES-1:0] v);
        lowest = '0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            if (v[i]) lowest = IDX_W'(i);
        end
    endfunction

    function automatic logic [NUM_STAGES-1:0] onehot(input logic [IDX_W-1:0] i);
        onehot = NUM_STAGES'(1) << i;
    endfunction

    // Candidate stages: any unbypassed stage at run start, or unbypassed stages past idx.
    generate
        for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_cand
            assign first_cand[gi] = ~bus.bypass_mask[gi];
            assign next_cand[gi]  = ~mask_reg[gi] && (IDX_W'(gi) > idx_reg);
        end
    endgenerate

    assign first_idx = lowest(first_cand);
    assign next_idx  = lowest(next_cand);
    assign first_any = |first_cand;
    assign next_any  = |next_cand;

    assign result           = (bus.relu_en && bus.final_in[DATA_W-1]) ? '0 : bus.final_in;
    assign cycle_count_next = (&cycle_count_reg) ? cycle_count_reg : cycle_count_reg + CNT_W'(1);
    assign timed_out        = (TIMEOUT != 0) && (wait_cnt_reg == WAIT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= S_IDLE;
            idx_reg         <= '0;
            wait_cnt_reg    <= '0;
            mask_reg        <= '0;
            stage_start_reg <= '0;
            value_reg       <= '0;
            done_reg        <= 1'b0;
            busy_reg        <= 1'b0;
            timeout_err_reg <= 1'b0;
            err_stage_reg   <= '0;
            cycle_count_reg <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (bus.enable) begin
                        mask_reg        <= bus.bypass_mask;
                        cycle_count_reg <= '0;
                        timeout_err_reg <= 1'b0;
                        if (first_any) begin
                            idx_reg         <= first_idx;
                            stage_start_reg <= onehot(first_idx);
                            busy_reg        <= 1'b1;
                            state_reg       <= S_LAUNCH;
                        end else begin
                            value_reg <= result;
                            done_reg  <= 1'b1;
                            state_reg <= S_FINISH;
                        end
                    end
                end
                S_LAUNCH: begin
                    stage_start_reg <= '0;
                    wait_cnt_reg    <= '0;
                    cycle_count_reg <= cycle_count_next;
                    state_reg       <= S_WAIT;
                end
                S_WAIT: begin
                    cycle_count_reg <= cycle_count_next;
                    // A done arriving on the last allowed cycle beats the timeout.
                    if (bus.stage_done[idx_reg]) begin
                        if (next_any) begin
                            idx_reg         <= next_idx;
                            stage_start_reg <= onehot(next_idx);
                            state_reg       <= S_LAUNCH;
                        end else begin
                            value_reg <= result;
                            done_reg  <= 1'b1;
                            busy_reg  <= 1'b0;
                            state_reg <= S_FINISH;
                        end
                    end else if (timed_out) begin
                        timeout_err_reg <= 1'b1;
                        err_stage_reg   <= idx_reg;
                        busy_reg        <= 1'b0;
                        state_reg       <= S_ERROR;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
                    end
                end
                S_FINISH: begin
                    done_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end
                S_ERROR: begin
                    if (!bus.enable) state_reg <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign bus.stage_start = stage_start_reg;
    assign bus.value       = value_reg;
    assign bus.done        = done_reg;
    assign bus.busy        = busy_reg;
    assign bus.timeout_err = timeout_err_reg;
    assign bus.err_stage   = err_stage_reg;
    assign bus.cycle_count = cycle_count_reg;
endmodule

// File: tb/tb_cnn_stage_sequencer.sv
// Randomized bench: each run is expanded into a per-cycle expected timeline that
// also dictates what the stage engines answer; a negedge process compares every cycle.
module tb_cnn_stage_sequencer;
    localparam int NS = 3;
    localparam int DW = 32;
    localparam int TO = 8;
    localparam int CW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cnn_stage_sequencer_if #(.NUM_STAGES(NS), .DATA_W(DW), .CNT_W(CW)) bus();

    cnn_stage_sequencer #(.NUM_STAGES(NS), .DATA_W(DW), .TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [2:0]  start;
        logic        busy;
        logic        done;
        logic        terr;
        logic [31:0] value;
        logic [31:0] cc;
        logic [1:0]  estage;
        int          en;          // 0 drive low, 1 drive high, 2 don't care (random)
        bit          force_mask;
        logic [2:0]  mask;
        logic [2:0]  sd_care;
        logic [2:0]  sd_val;
        bit          cap;
        bit          relu;
        logic [31:0] fin;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_value  = '0;
    logic [31:0] m_cc     = '0;
    logic        m_terr   = 1'b0;
    logic [1:0]  m_estage = '0;
    int          checks   = 0;
    int          errors   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic ent_t idle_ent();
        ent_t e;
        e.start = '0; e.busy = 1'b0; e.done = 1'b0; e.terr = m_terr;
        e.value = m_value; e.cc = m_cc; e.estage = m_estage;
        e.en = 0; e.force_mask = 1'b0; e.mask = '0;
        e.sd_care = '0; e.sd_val = '0; e.cap = 1'b0; e.relu = 1'b0; e.fin = '0;
        return e;
    endfunction

    always @(negedge clk) begin : cmp
        ent_t e;
        if (q.size() > 0) e = q.pop_front();
        else              e = idle_ent();
        chk("stage_start", 32'(bus.stage_start), 32'(e.start));
        chk("busy",        32'(bus.busy),        32'(e.busy));
        chk("done",        32'(bus.done),        32'(e.done));
        chk("timeout_err", 32'(bus.timeout_err), 32'(e.terr));
        chk("err_stage",   32'(bus.err_stage),   32'(e.estage));
        chk("value",       bus.value,            e.value);
        chk("cycle_count", bus.cycle_count,      e.cc);
    end

    // Lat < 0 means the stage never answers. Lat n means done during the n-th WAIT cycle.
    task automatic plan_run(input logic [2:0] mask, input int l0, input int l1, input int l2,
                            input bit relu, input logic [31:0] fin);
        int          lat[3];
        int          last;
        int          n;
        ent_t        e;
        logic [31:0] cc;
        logic [31:0] capt;
        lat  = '{l0, l1, l2};
        last = -1;
        cc   = 0;
        for (int s = 0; s < NS; s++) if (!mask[s]) last = s;
        capt = (relu && fin[31]) ? 32'd0 : fin;
        e = idle_ent();
        e.en = 1; e.force_mask = 1'b1; e.mask = mask;
        if (last < 0) begin e.cap = 1'b1; e.relu = relu; e.fin = fin; end
        q.push_back(e);
        for (int s = 0; s < NS; s++) begin
            if (mask[s]) continue;
            e = idle_ent();
            e.terr = 1'b0; e.start = 3'(1 << s); e.busy = 1'b1; e.cc = cc; e.en = 2;
            q.push_back(e);
            cc++;
            n = (lat[s] < 0) ? TO : lat[s];
            for (int w = 1; w <= n; w++) begin
                e = idle_ent();
                e.terr = 1'b0; e.busy = 1'b1; e.cc = cc; e.en = 2;
                e.sd_care = 3'(1 << s);
                e.sd_val  = (lat[s] >= 0 && w == n) ? 3'(1 << s) : 3'b000;
                e.cap  = (lat[s] >= 0 && w == n && s == last);
                e.relu = relu; e.fin = fin;
                q.push_back(e);
                cc++;
            end
            if (lat[s] < 0) begin
                for (int h = 0; h < 4; h++) begin
                    e = idle_ent();
                    e.terr = 1'b1; e.estage = 2'(s); e.cc = cc; e.en = (h < 3) ? 1 : 0;
                    q.push_back(e);
                end
                m_terr = 1'b1; m_estage = 2'(s); m_cc = cc;
                return;
            end
        end
        e = idle_ent();
        e.terr = 1'b0; e.done = 1'b1; e.value = capt; e.cc = cc;
        q.push_back(e);
        m_value = capt; m_cc = cc; m_terr = 1'b0;
    endtask

    task automatic drive();
        if (q.size() > 0) begin
            ent_t e = q[0];
            bus.enable      = (e.en == 2) ? 1'($urandom) : (e.en == 1);
            bus.bypass_mask = e.force_mask ? e.mask : 3'($urandom);
            bus.stage_done  = (3'($urandom) & ~e.sd_care) | (e.sd_val & e.sd_care);
            if (e.cap) begin bus.relu_en = e.relu; bus.final_in = e.fin; end
            else begin bus.relu_en = 1'($urandom); bus.final_in = $urandom; end
        end else begin
            bus.enable      = 1'b0;
            bus.bypass_mask = 3'($urandom);
            bus.stage_done  = 3'($urandom);
            bus.relu_en     = 1'($urandom);
            bus.final_in    = $urandom;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
        drive();
    endtask

    task automatic start_run(input logic [2:0] mask, input int l0, input int l1, input int l2,
                             input bit relu, input logic [31:0] fin);
        plan_run(mask, l0, l1, l2, relu, fin);
        drive();
    endtask

    task automatic drain();
        int g = 0;
        while (q.size() > 0 && g < 300) begin
            step();
            g++;
        end
        if (q.size() > 0) chk("drain_bound", 32'(q.size()), 32'd0);
    endtask

    initial begin
        drive();
        repeat (3) step();
        chk("reset_cc", bus.cycle_count, 32'd0);
        chk("reset_value", bus.value, 32'd0);
        rst = 1'b0;
        step();

        // Full chain, negative result clamped by ReLU.
        start_run(3'b000, 5, 5, 5, 1'b1, -32'sd7); drain();
        chk("t1_value", bus.value, 32'd0);
        chk("t1_cc", bus.cycle_count, 32'd18);
        chk("t1_busy", 32'(bus.busy), 32'd0);

        start_run(3'b000, 5, 5, 5, 1'b0, -32'sd7); drain();
        chk("t2_value_neg", bus.value, 32'hFFFF_FFF9);
        start_run(3'b000, 5, 5, 5, 1'b1, 32'd42); drain();
        chk("t2_value_pos", bus.value, 32'd42);

        // Middle stage bypassed; its done bit is randomly toggled throughout.
        start_run(3'b010, 5, 5, 5, 1'b0, 32'd9); drain();
        chk("t3_cc", bus.cycle_count, 32'd12);

        // All bypassed: immediate finish.
        start_run(3'b111, 5, 5, 5, 1'b0, 32'd5); drain();
        chk("t4_value", bus.value, 32'd5);
        chk("t4_cc", bus.cycle_count, 32'd0);

        // Stage 1 never answers.
        start_run(3'b000, 5, -1, 5, 1'b0, 32'd1); drain();
        chk("t5_terr", 32'(bus.timeout_err), 32'd1);
        chk("t5_estage", 32'(bus.err_stage), 32'd1);
        chk("t5_cc", bus.cycle_count, 32'd15);
        start_run(3'b000, 3, 4, 2, 1'b0, 32'd77); drain();
        chk("t5_terr_cleared", 32'(bus.timeout_err), 32'd0);
        chk("t5_value", bus.value, 32'd77);

        // Done on the last allowed WAIT cycle still counts as done.
        start_run(3'b000, 8, 1, 8, 1'b0, 32'd123); drain();
        chk("edge_cc", bus.cycle_count, 32'd20);
        chk("edge_terr", 32'(bus.timeout_err), 32'd0);

        // Asynchronous reset in the middle of stage 1's WAIT.
        start_run(3'b000, 5, 5, 5, 1'b0, 32'd100);
        repeat (9) step();
        chk("t6_busy_before", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("t6_start", 32'(bus.stage_start), 32'd0);
        chk("t6_busy", 32'(bus.busy), 32'd0);
        chk("t6_done", 32'(bus.done), 32'd0);
        chk("t6_terr", 32'(bus.timeout_err), 32'd0);
        chk("t6_estage", 32'(bus.err_stage), 32'd0);
        chk("t6_value", bus.value, 32'd0);
        chk("t6_cc", bus.cycle_count, 32'd0);
        q.delete();
        m_value = '0; m_cc = '0; m_terr = 1'b0; m_estage = '0;
        step();
        step();
        rst = 1'b0;
        start_run(3'b000, 2, 2, 2, 1'b1, -32'sd3); drain();
        chk("t6_restart_cc", bus.cycle_count, 32'd9);

        for (int r = 0; r < 25; r++) begin
            int          l[3];
            logic [2:0]  mask;
            logic [31:0] fin;
            bit          relu;
            mask = 3'($urandom);
            for (int s = 0; s < NS; s++)
                l[s] = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(1, 8));
            relu = 1'($urandom);
            fin  = $urandom;
            $display("run %0d: mask=%b lat=%0d,%0d,%0d relu=%0d fin=%h",
                     r, mask, l[0], l[1], l[2], relu, fin);
            start_run(mask, l[0], l[1], l[2], relu, fin);
            drain();
        end

        step();
        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
